// File: rtl/vga_timing_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen_pkg
//  Purpose  : Shared definitions for the parametrised VGA/DVI raster timing
//             generator. This package provides:
//               - the standard mode constants (640x480@60, 800x600@60,
//                 1024x768@60);
//               - the sync polarity encodings;
//               - the bundle of level signals that travels through the
//                 output delay pipeline;
//               - a helper that sums one axis of a timing mode.
//  Ports    : none (package)
//  Config   : VGA_TIMING_FRAME_CNT_EN adds the vblank field to the
//             delayed bundle.
//  Revision : 1.0  initial release
// ============================================================================
package vga_timing_gen_pkg;

  // Sync polarity encodings (value of the sync pin while sync is active)
  localparam int POL_ACTIVE_LOW  = 0;
  localparam int POL_ACTIVE_HIGH = 1;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock (default mode)
  localparam int M640_H_ACTIVE = 640;
  localparam int M640_H_FP     = 16;
  localparam int M640_H_SYNC   = 96;
  localparam int M640_H_BP     = 48;
  localparam int M640_V_ACTIVE = 480;
  localparam int M640_V_FP     = 10;
  localparam int M640_V_SYNC   = 2;
  localparam int M640_V_BP     = 33;
  localparam int M640_HS_POL   = POL_ACTIVE_LOW;
  localparam int M640_VS_POL   = POL_ACTIVE_LOW;

  // 800x600 @ 60 Hz, 40 MHz pixel clock
  localparam int M800_H_ACTIVE = 800;
  localparam int M800_H_FP     = 40;
  localparam int M800_H_SYNC   = 128;
  localparam int M800_H_BP     = 88;
  localparam int M800_V_ACTIVE = 600;
  localparam int M800_V_FP     = 1;
  localparam int M800_V_SYNC   = 4;
  localparam int M800_V_BP     = 23;
  localparam int M800_HS_POL   = POL_ACTIVE_HIGH;
  localparam int M800_VS_POL   = POL_ACTIVE_HIGH;

  // 1024x768 @ 60 Hz, 65 MHz pixel clock (needs CNT_W >= 11)
  localparam int M1024_H_ACTIVE = 1024;
  localparam int M1024_H_FP     = 24;
  localparam int M1024_H_SYNC   = 136;
  localparam int M1024_H_BP     = 160;
  localparam int M1024_V_ACTIVE = 768;
  localparam int M1024_V_FP     = 3;
  localparam int M1024_V_SYNC   = 6;
  localparam int M1024_V_BP     = 29;
  localparam int M1024_HS_POL   = POL_ACTIVE_LOW;
  localparam int M1024_VS_POL   = POL_ACTIVE_LOW;

  // Level signals delayed together to line up with framebuffer read data
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic vblank;
`endif
  } sync_bundle_t;

  // Total length of one axis (sync + back porch + active + front porch)
  function automatic int axis_total(input int sync_w, input int bp,
                                    input int active, input int fp);
    return sync_w + bp + active + fp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen_if
//  Purpose  : Pixel-side signal bundle of the VGA timing generator.
//             The master modport is used by the generator and the slave
//             modport by the consumer (pins / framebuffer reader).
//  Signals  : pix_en_i      pixel step enable (into the generator)
//             vga_hs_o      hsync, delayed
//             vga_vs_o      vsync, delayed
//             envalid_o     active-video enable, delayed
//             pos_x/pos_y   active-area coordinate, CNT_W bits
//             line_start_o  1-clk pulse at line start
//             frame_start_o 1-clk pulse at frame start
//             frame_cnt_o   16-bit frame counter   (VGA_TIMING_FRAME_CNT_EN)
//             vblank_o      vertical blanking flag (VGA_TIMING_FRAME_CNT_EN)
//  Revision : 1.0  initial release
// ============================================================================
interface vga_timing_gen_if #(
  parameter int CNT_W = 10
);
  logic             pix_en_i;
  logic             vga_hs_o;
  logic             vga_vs_o;
  logic             envalid_o;
  logic [CNT_W-1:0] pos_x;
  logic [CNT_W-1:0] pos_y;
  logic             line_start_o;
  logic             frame_start_o;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]      frame_cnt_o;
  logic             vblank_o;

  modport master (
    input  pix_en_i,
    output vga_hs_o, vga_vs_o, envalid_o, pos_x, pos_y,
           line_start_o, frame_start_o, frame_cnt_o, vblank_o
  );
  modport slave (
    output pix_en_i,
    input  vga_hs_o, vga_vs_o, envalid_o, pos_x, pos_y,
           line_start_o, frame_start_o, frame_cnt_o, vblank_o
  );
`else
  modport master (
    input  pix_en_i,
    output vga_hs_o, vga_vs_o, envalid_o, pos_x, pos_y,
           line_start_o, frame_start_o
  );
  modport slave (
    output pix_en_i,
    input  vga_hs_o, vga_vs_o, envalid_o, pos_x, pos_y,
           line_start_o, frame_start_o
  );
`endif
endinterface
`default_nettype wire

// File: rtl/vga_timing_delay.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_delay
//  Purpose  : WIDTH x DELAY shift register that advances only when en = 1.
//             All stages load rst_val on asynchronous reset. When DELAY is 0
//             the module is a pure wire.
//  Ports    : clk      clock
//             rst      asynchronous active-high reset
//             en       shift enable (pixel step)
//             rst_val  value loaded into every stage on reset
//             din      pipeline input
//             dout     pipeline output, DELAY enabled steps after din
//  Revision : 1.0  initial release
// ============================================================================
module vga_timing_delay #(
  parameter int WIDTH = 3,
  parameter int DELAY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DELAY == 0) begin : g_bypass
      // Clock, reset and enable have no use in the zero-latency build.
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clk, rst, en, rst_val};
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DELAY];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DELAY; i++) begin
            stage[i] <= rst_val;
          end
        end else if (en) begin
          stage[0] <= din;
          for (int i = 1; i < DELAY; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign dout = stage[DELAY-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Parametrised VGA/DVI raster timing generator. The line order
//             from count 0 is: sync, back porch, active, front porch.
//             The counters advance on each clock with pix_en_i = 1.
//             Stage 0 registers the coordinates, the start pulses and the
//             decoded sync/enable levels. The levels then pass through DELAY
//             further pixel-qualified stages, which cover framebuffer read
//             latency.
//  Ports    : clk_i     clock
//             reset_i   asynchronous active-high reset
//             vif       vga_timing_gen_if.master (pix_en_i in, raster out)
//  Config   : VGA_TIMING_FRAME_CNT_EN adds frame_cnt_o and vblank_o.
//  Revision : 1.0  initial release
// ============================================================================
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE = M640_H_ACTIVE,
  parameter int H_FP     = M640_H_FP,
  parameter int H_SYNC   = M640_H_SYNC,
  parameter int H_BP     = M640_H_BP,
  parameter int V_ACTIVE = M640_V_ACTIVE,
  parameter int V_FP     = M640_V_FP,
  parameter int V_SYNC   = M640_V_SYNC,
  parameter int V_BP     = M640_V_BP,
  parameter int HS_POL   = M640_HS_POL,
  parameter int VS_POL   = M640_VS_POL,
  parameter int CNT_W    = 10,
  parameter int DELAY    = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  vga_timing_gen_if.master   vif
);

  localparam int H_TOTAL = axis_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int V_TOTAL = axis_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;

  // Elaboration-time parameter checks
  generate
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_err_zero
      $error("vga_timing_gen: every porch, sync and active length must be >= 1");
    end
    if (CNT_W < 1 || CNT_W > 30 ||
        (H_TOTAL - 1) > ((2 ** CNT_W) - 1) ||
        (V_TOTAL - 1) > ((2 ** CNT_W) - 1)) begin : g_err_width
      $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
    end
    if (DELAY < 0 || DELAY > 4) begin : g_err_delay
      $error("vga_timing_gen: DELAY must be in 0..4");
    end
  endgenerate

  // Counter-width copies of the timing boundaries. Every boundary value is
  // at most TOTAL-1, because the front porch is at least 1, so none of them
  // is truncated.
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYN_E = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYN_E = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_S = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] V_ACT_S = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] H_ACT_E = CNT_W'(H_START + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_E = CNT_W'(V_START + V_ACTIVE);
  localparam logic             HS_ON   = (HS_POL != 0);
  localparam logic             VS_ON   = (VS_POL != 0);

  logic             pix_en;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  assign pix_en = vif.pix_en_i;

  // --------------------------------------------------------------------------
  // Raster counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) begin
          v_cnt <= '0;
        end else begin
          v_cnt <= v_cnt + ONE;
        end
      end else begin
        h_cnt <= h_cnt + ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Decode of the current counter state
  // --------------------------------------------------------------------------
  logic         h_sync_act;
  logic         v_sync_act;
  logic         h_act;
  logic         v_act;
  logic         line_hit;
  logic         frame_hit;
  sync_bundle_t sync_dec;
  sync_bundle_t sync_rst;

  assign h_sync_act = (h_cnt < H_SYN_E);
  assign v_sync_act = (v_cnt < V_SYN_E);
  assign h_act      = (h_cnt >= H_ACT_S) && (h_cnt < H_ACT_E);
  assign v_act      = (v_cnt >= V_ACT_S) && (v_cnt < V_ACT_E);
  assign line_hit   = (h_cnt == '0);
  assign frame_hit  = (h_cnt == '0) && (v_cnt == '0);

  always_comb begin
    sync_dec    = '0;
    sync_dec.hs = h_sync_act ? HS_ON : ~HS_ON;
    sync_dec.vs = v_sync_act ? VS_ON : ~VS_ON;
    sync_dec.de = h_act && v_act;
`ifdef VGA_TIMING_FRAME_CNT_EN
    sync_dec.vblank = ~v_act;
`endif
  end

  // Idle levels: sync inactive, no video, blanking
  always_comb begin
    sync_rst    = '0;
    sync_rst.hs = ~HS_ON;
    sync_rst.vs = ~VS_ON;
    sync_rst.de = 1'b0;
`ifdef VGA_TIMING_FRAME_CNT_EN
    sync_rst.vblank = 1'b1;
`endif
  end

  // --------------------------------------------------------------------------
  // Stage 0: coordinates, pulses and decoded levels, one step after the state
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] pos_x_q;
  logic [CNT_W-1:0] pos_y_q;
  logic             line_start_q;
  logic             frame_start_q;
  sync_bundle_t     sync_s0;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pos_x_q       <= '0;
      pos_y_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      sync_s0       <= sync_rst;
    end else begin
      // Pulses are only ever one clock wide, even when pix_en is sparse.
      line_start_q  <= pix_en && line_hit;
      frame_start_q <= pix_en && frame_hit;
      if (pix_en) begin
        sync_s0 <= sync_dec;
        if (h_act && v_act) begin
          pos_x_q <= h_cnt - H_ACT_S;
          pos_y_q <= v_cnt - V_ACT_S;
        end else begin
          pos_x_q <= '0;
          pos_y_q <= '0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Level delay pipeline
  // --------------------------------------------------------------------------
  sync_bundle_t sync_out;

  vga_timing_delay #(
    .WIDTH ($bits(sync_bundle_t)),
    .DELAY (DELAY)
  ) u_delay (
    .clk     (clk_i),
    .rst     (reset_i),
    .en      (pix_en),
    .rst_val (sync_rst),
    .din     (sync_s0),
    .dout    (sync_out)
  );

  assign vif.vga_hs_o      = sync_out.hs;
  assign vif.vga_vs_o      = sync_out.vs;
  assign vif.envalid_o     = sync_out.de;
  assign vif.pos_x         = pos_x_q;
  assign vif.pos_y         = pos_y_q;
  assign vif.line_start_o  = line_start_q;
  assign vif.frame_start_o = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  // --------------------------------------------------------------------------
  // Frame counter: updates together with frame_start_o
  // --------------------------------------------------------------------------
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      frame_cnt_q <= '0;
    end else if (pix_en && frame_hit) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign vif.frame_cnt_o = frame_cnt_q;
  assign vif.vblank_o    = sync_out.vblank;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Purpose  : Self-checking bench for vga_timing_gen. It runs three
//             instances: the default 640x480 mode with DELAY=1, a tiny
//             active-high mode with DELAY=2, and a tiny active-low mode with
//             DELAY=0. Expected outputs come from the number of pixel steps
//             taken since reset and are queued when stimulus is driven.
//  Config   : VGA_TIMING_FRAME_CNT_EN also checks frame_cnt_o and vblank_o.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;
  logic pix_en;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CNT_W(10)) if_a ();
  vga_timing_gen_if #(.CNT_W(4))  if_b ();
  vga_timing_gen_if #(.CNT_W(5))  if_c ();

  assign if_a.pix_en_i = pix_en;
  assign if_b.pix_en_i = pix_en;
  assign if_c.pix_en_i = pix_en;

  vga_timing_gen u_a (
    .clk_i (clk), .reset_i (rst), .vif (if_a)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (1), .H_SYNC (1), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HS_POL (1), .VS_POL (1), .CNT_W (4), .DELAY (2)
  ) u_b (
    .clk_i (clk), .reset_i (rst), .vif (if_b)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (1), .H_SYNC (1), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HS_POL (0), .VS_POL (0), .CNT_W (5), .DELAY (0)
  ) u_c (
    .clk_i (clk), .reset_i (rst), .vif (if_c)
  );

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        ls;
    logic        fs;
    logic        vb;
    logic [9:0]  px;
    logic [9:0]  py;
    logic [15:0] fc;
  } obs_t;

  obs_t   q_a[$];
  obs_t   q_b[$];
  obs_t   q_c[$];
  int     errors = 0;
  int     checks = 0;
  longint k = 0;        // pixel steps since reset release
  longint cyc = 0;      // clocks since start
  int     de_cnt_a = 0;
  int     hs_cnt_a = 0;
  longint last_fs_b = -1;
  int     period_mult = 0;

  // Expected outputs after k steps. Stage 0 shows state k-1; the delayed
  // levels show state k-1-d, with idle levels before the first such state.
  function automatic obs_t model(input longint kk, input bit en_last,
                                 input int ha, input int hf, input int hsy, input int hbp,
                                 input int va, input int vf, input int vsy, input int vbp,
                                 input bit hp, input bit vp, input int d);
    obs_t   e;
    int     ht, vt, h, v, hst, vst;
    longint s;
    ht = ha + hf + hsy + hbp;
    vt = va + vf + vsy + vbp;
    hst = hsy + hbp;
    vst = vsy + vbp;
    e = '0;
    e.hs = ~hp;
    e.vs = ~vp;
    e.vb = 1'b1;
    if (kk > 0) begin
      s = kk - 1;
      h = int'(s % ht);
      v = int'((s / ht) % vt);
      if (h >= hst && h < hst + ha && v >= vst && v < vst + va) begin
        e.px = 10'(h - hst);
        e.py = 10'(v - vst);
      end
      e.ls = en_last && (h == 0);
      e.fs = en_last && (h == 0) && (v == 0);
      e.fc = 16'((s / (ht * vt) + 1) % 65536);
    end
    s = kk - 1 - d;
    if (s >= 0) begin
      h = int'(s % ht);
      v = int'((s / ht) % vt);
      e.hs = (h < hsy) ? hp : ~hp;
      e.vs = (v < vsy) ? vp : ~vp;
      e.de = (h >= hst && h < hst + ha && v >= vst && v < vst + va);
      e.vb = !(v >= vst && v < vst + va);
    end
    return e;
  endfunction

  function automatic obs_t mask(input obs_t e);
    obs_t m;
    m = e;
`ifndef VGA_TIMING_FRAME_CNT_EN
    m.vb = 1'b0;
    m.fc = '0;
`endif
    return m;
  endfunction

  function automatic obs_t exp_a(input longint kk, input bit en);
    return mask(model(kk, en, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 1));
  endfunction
  function automatic obs_t exp_b(input longint kk, input bit en);
    return mask(model(kk, en, 8, 1, 1, 2, 4, 1, 1, 1, 1'b1, 1'b1, 2));
  endfunction
  function automatic obs_t exp_c(input longint kk, input bit en);
    return mask(model(kk, en, 8, 1, 1, 2, 4, 1, 1, 1, 1'b0, 1'b0, 0));
  endfunction

  function automatic obs_t get_a();
    obs_t o;
    o = '0;
    o.hs = if_a.vga_hs_o;  o.vs = if_a.vga_vs_o;  o.de = if_a.envalid_o;
    o.ls = if_a.line_start_o;  o.fs = if_a.frame_start_o;
    o.px = if_a.pos_x;  o.py = if_a.pos_y;
`ifdef VGA_TIMING_FRAME_CNT_EN
    o.vb = if_a.vblank_o;  o.fc = if_a.frame_cnt_o;
`endif
    return o;
  endfunction
  function automatic obs_t get_b();
    obs_t o;
    o = '0;
    o.hs = if_b.vga_hs_o;  o.vs = if_b.vga_vs_o;  o.de = if_b.envalid_o;
    o.ls = if_b.line_start_o;  o.fs = if_b.frame_start_o;
    o.px = 10'(if_b.pos_x);  o.py = 10'(if_b.pos_y);
`ifdef VGA_TIMING_FRAME_CNT_EN
    o.vb = if_b.vblank_o;  o.fc = if_b.frame_cnt_o;
`endif
    return o;
  endfunction
  function automatic obs_t get_c();
    obs_t o;
    o = '0;
    o.hs = if_c.vga_hs_o;  o.vs = if_c.vga_vs_o;  o.de = if_c.envalid_o;
    o.ls = if_c.line_start_o;  o.fs = if_c.frame_start_o;
    o.px = 10'(if_c.pos_x);  o.py = 10'(if_c.pos_y);
`ifdef VGA_TIMING_FRAME_CNT_EN
    o.vb = if_c.vblank_o;  o.fc = if_c.frame_cnt_o;
`endif
    return o;
  endfunction

  task automatic check(input string tag, input obs_t obs, input obs_t expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s step=%0d observed=%h expected=%h", tag, k, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, k, obs, expv);
    end
  endtask

  // One clock: drive pix_en, queue expectations, sample #1 after the edge
  task automatic step(input bit en);
    obs_t oa, ob;
    pix_en = en;
    if (en && !rst) k++;
    q_a.push_back(exp_a(k, en && !rst));
    q_b.push_back(exp_b(k, en && !rst));
    q_c.push_back(exp_c(k, en && !rst));
    @(posedge clk);
    #1;
    cyc++;
    oa = get_a();
    ob = get_b();
    check("a_out", oa, q_a.pop_front());
    check("b_out", ob, q_b.pop_front());
    check("c_out", get_c(), q_c.pop_front());
    // Per-line counts of envalid and hsync-active steps on the 640x480 unit
    if (oa.ls) begin
      if (de_cnt_a != 0) check_int("a_de_per_line", de_cnt_a, 640);
      if (hs_cnt_a != 0) check_int("a_hs_per_line", hs_cnt_a, 96);
      de_cnt_a = 0;
      hs_cnt_a = 0;
    end
    if (en) begin
      if (oa.de) de_cnt_a++;
      if (!oa.hs) hs_cnt_a++;
    end
    // Frame period of the tiny unit in clocks (12 x 7 steps)
    if (ob.fs) begin
      if (last_fs_b >= 0 && period_mult > 0)
        check_int("b_frame_period", cyc - last_fs_b, longint'(84 * period_mult));
      last_fs_b = cyc;
    end
  endtask

  // Assert reset between edges and check outputs before any clock edge
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    k = 0;
    check("a_async_rst", get_a(), exp_a(0, 1'b0));
    check("b_async_rst", get_b(), exp_b(0, 1'b0));
    check("c_async_rst", get_c(), exp_c(0, 1'b0));
    de_cnt_a = 0;
    hs_cnt_a = 0;
    last_fs_b = -1;
    step(1'b1);
    step(1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    pix_en = 1'b0;
    #1;
    check("a_reset", get_a(), exp_a(0, 1'b0));
    check("b_reset", get_b(), exp_b(0, 1'b0));
    check("c_reset", get_c(), exp_c(0, 1'b0));
    step(1'b0);
    step(1'b1);
    step(1'b0);
    rst = 1'b0;

    // Continuous pixel enable: reaches the first active lines of 640x480
    period_mult = 1;
    repeat (30000) step(1'b1);

    // Mid-frame reset, then pixel enable on every other clock
    async_reset();
    period_mult = 2;
    repeat (3000) begin
      step(1'b1);
      step(1'b0);
    end

    // Irregular pixel enable
    period_mult = 0;
    repeat (4000) step(1'($urandom_range(0, 1)));

    // Reset again and run continuously
    async_reset();
    period_mult = 1;
    repeat (2000) step(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
